btn_event_arbiter: RTL and testbench

Collects single-cycle press pulses from up to N per-button edge detectors and serialises them into one event stream of button IDs for a single consumer (display/FSM logic) over a valid/ready handshake. Holds one pending request per button, arbitrates round-robin, and enforces a per-button re-trigger lockout. Reports any pulse that could not be queued through a sticky `evt_lost` flag. Sits between the edge-detector bank and the application control logic.

---
 rtl/btn_event_if.sv | 29 ++
 rtl/btn_event_arbiter.sv | 121 ++++++++++++
 tb/tb_btn_event_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_if
// Description : Press-pulse inputs, event valid/ready stream and loss flag
//               between the button edge-detector bank and the arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface btn_event_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   pulse_in;
    logic           evt_ready;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           clr_lost;
    logic           evt_lost;

    modport master (
        output pulse_in, evt_ready, clr_lost,
        input  evt_valid, evt_id, evt_lost
    );

    modport slave (
        input  pulse_in, evt_ready, clr_lost,
        output evt_valid, evt_id, evt_lost
    );
endinterface
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_arbiter
// Description : Queues one press per button, serialises them round-robin onto
//               a valid/ready event stream with per-button re-trigger lockout.
// Revision    : 1.0  initial release
// ============================================================================
module btn_event_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int LOCKOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    btn_event_if.slave bus
);

    localparam logic [7:0]     c_lockout = 8'(LOCKOUT);
    localparam logic           c_requeue = (LOCKOUT == 0);
    localparam logic [IDW:0]   c_n_ext   = (IDW + 1)'(N);
    localparam logic [IDW:0]   c_n_m1    = (IDW + 1)'(N - 1);
    localparam logic [IDW-1:0] c_one     = IDW'(1);

    logic [IDW-1:0] r_ptr;
    logic           r_evt_valid;
    logic [IDW-1:0] r_evt_id;
    logic           r_evt_lost;

    logic [N-1:0]   w_pending;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_grant_vec;
    logic [N-1:0]   w_drop;
    logic           w_slot_free;
    logic           w_found;
    logic           w_grant;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_grant_id;
    logic [IDW-1:0] w_ptr_next;

    assign w_slot_free = !r_evt_valid || bus.evt_ready;

    // Rotate so bit 0 is the button at r_ptr; first set bit wins.
    always_comb begin
        w_rot   = N'({w_pending, w_pending} >> r_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (IDW + 1)'(j);
            end
        end
        w_grant    = w_found && w_slot_free;
        w_grant_id = (w_sum >= c_n_ext) ? IDW'(w_sum - c_n_ext) : IDW'(w_sum);
    end

    assign w_ptr_next = ({1'b0, w_grant_id} == c_n_m1) ? '0 : w_grant_id + c_one;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_btn
            logic       r_pending;
            logic [7:0] r_lock_cnt;
            logic       w_unlocked;

            assign w_unlocked      = (r_lock_cnt == 8'd0);
            assign w_grant_vec[gi] = w_grant && (w_grant_id == IDW'(gi));
            assign w_pending[gi]   = r_pending;
            assign w_drop[gi]      = bus.pulse_in[gi] && w_unlocked && r_pending
                                     && !w_grant_vec[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pending  <= 1'b0;
                    r_lock_cnt <= 8'd0;
                end else begin
                    if (w_grant_vec[gi]) begin
                        r_lock_cnt <= c_lockout;
                    end else if (!w_unlocked) begin
                        r_lock_cnt <= r_lock_cnt - 8'd1;
                    end
                    // A press coinciding with its own grant re-queues only without lockout.
                    if (w_grant_vec[gi]) begin
                        r_pending <= c_requeue && bus.pulse_in[gi];
                    end else if (bus.pulse_in[gi] && w_unlocked) begin
                        r_pending <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_evt_lost  <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_evt_valid <= w_grant;
                if (w_grant) begin
                    r_evt_id <= w_grant_id;
                end
            end
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end
            if (|w_drop) begin
                r_evt_lost <= 1'b1;
            end else if (bus.clr_lost) begin
                r_evt_lost <= 1'b0;
            end
        end
    end

    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_id    = r_evt_id;
    assign bus.evt_lost  = r_evt_lost;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_arbiter
// Description : Two arbiters (LOCKOUT=8 and LOCKOUT=0) driven with directed
//               press sequences and checked against a timestamp-based model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_btn_event_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LO_A = 8;
    localparam int LO_B = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_event_if #(.N(N), .IDW(IDW)) bus_a ();
    btn_event_if #(.N(N), .IDW(IDW)) bus_b ();

    btn_event_arbiter #(.N(N), .IDW(IDW), .LOCKOUT(LO_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    btn_event_arbiter #(.N(N), .IDW(IDW), .LOCKOUT(LO_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_pass;
    int n_total;

    // Model: pending set, time of last grant per button, pointer, output slot.
    bit m_pend    [2][N];
    int m_grant_t [2][N];
    int m_ptr     [2];
    bit m_valid   [2];
    int m_id      [2];
    bit m_lost    [2];
    int m_cyc;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_pend[d][i]    = 1'b0;
                m_grant_t[d][i] = -1000;
            end
            m_ptr[d]   = 0;
            m_valid[d] = 1'b0;
            m_id[d]    = 0;
            m_lost[d]  = 1'b0;
        end
    endtask

    task automatic model_edge(int d, logic [N-1:0] p, logic rdy, logic clr);
        int lo;
        int g;
        bit free;
        bit lost_now;
        bit locked;
        bit nxt [N];
        lo       = (d == 0) ? LO_A : LO_B;
        g        = -1;
        free     = !m_valid[d] || rdy;
        lost_now = 1'b0;
        if (free) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[d][(m_ptr[d] + k) % N]) g = (m_ptr[d] + k) % N;
        end
        for (int i = 0; i < N; i++) begin
            nxt[i] = m_pend[d][i] && (i != g);
            locked = (m_cyc > m_grant_t[d][i]) && ((m_cyc - m_grant_t[d][i]) <= lo);
            if (p[i] && !locked) begin
                if (i == g) nxt[i] = (lo == 0);
                else if (m_pend[d][i]) lost_now = 1'b1;
                else nxt[i] = 1'b1;
            end
        end
        if (g >= 0) begin
            m_valid[d]      = 1'b1;
            m_id[d]         = g;
            m_ptr[d]        = (g + 1) % N;
            m_grant_t[d][g] = m_cyc;
        end else if (free) begin
            m_valid[d] = 1'b0;
        end
        if (lost_now) m_lost[d] = 1'b1;
        else if (clr) m_lost[d] = 1'b0;
        for (int i = 0; i < N; i++) m_pend[d][i] = nxt[i];
    endtask

    task automatic compare_model();
        chk("model_a_valid", int'(bus_a.evt_valid), int'(m_valid[0]));
        chk("model_a_id",    int'(bus_a.evt_id),    m_id[0]);
        chk("model_a_lost",  int'(bus_a.evt_lost),  int'(m_lost[0]));
        chk("model_b_valid", int'(bus_b.evt_valid), int'(m_valid[1]));
        chk("model_b_id",    int'(bus_b.evt_id),    m_id[1]);
        chk("model_b_lost",  int'(bus_b.evt_lost),  int'(m_lost[1]));
    endtask

    // Inputs set before this call are the ones sampled at the coming rising edge.
    task automatic cycle();
        if (rst) begin
            model_reset();
        end else begin
            model_edge(0, bus_a.pulse_in, bus_a.evt_ready, bus_a.clr_lost);
            model_edge(1, bus_b.pulse_in, bus_b.evt_ready, bus_b.clr_lost);
        end
        m_cyc++;
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        m_cyc           = 0;
        rst             = 1'b1;
        bus_a.pulse_in  = '0;
        bus_a.evt_ready = 1'b0;
        bus_a.clr_lost  = 1'b0;
        bus_b.pulse_in  = '0;
        bus_b.evt_ready = 1'b0;
        bus_b.clr_lost  = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_valid", int'(bus_a.evt_valid), 0);
        chk("reset_id",    int'(bus_a.evt_id),    0);
        chk("reset_lost",  int'(bus_a.evt_lost),  0);

        // Single press on button 2, LOCKOUT=8
        bus_a.evt_ready = 1'b1;
        bus_b.evt_ready = 1'b1;
        cycle();
        bus_a.pulse_in = 4'b0100; cycle();
        bus_a.pulse_in = 4'b0000; cycle();
        chk("single_valid_e1", int'(bus_a.evt_valid), 1);
        chk("single_id_e1",    int'(bus_a.evt_id),    2);
        cycle();
        chk("single_valid_e2", int'(bus_a.evt_valid), 0);
        chk("single_lost",     int'(bus_a.evt_lost),  0);

        // Simultaneous presses 0,1,3 then fairness after the wrap (LOCKOUT=0)
        bus_b.pulse_in = 4'b1011; cycle();
        bus_b.pulse_in = 4'b0000; cycle();
        chk("simul_id0", int'(bus_b.evt_id), 0);
        cycle(); chk("simul_id1", int'(bus_b.evt_id), 1);
        cycle(); chk("simul_id3", int'(bus_b.evt_id), 3);
        cycle(); chk("simul_idle", int'(bus_b.evt_valid), 0);
        bus_b.pulse_in = 4'b1001; cycle();
        bus_b.pulse_in = 4'b0000; cycle();
        chk("rr_wrap_first0", int'(bus_b.evt_id), 0);
        cycle(); chk("rr_wrap_then3", int'(bus_b.evt_id), 3);
        cycle();
        bus_b.pulse_in = 4'b0010; cycle();
        bus_b.pulse_in = 4'b0101; cycle();
        chk("rr_grant1", int'(bus_b.evt_id), 1);
        bus_b.pulse_in = 4'b0000; cycle();
        chk("rr_first2", int'(bus_b.evt_id), 2);
        cycle(); chk("rr_then0", int'(bus_b.evt_id), 0);
        cycle(); chk("rr_idle", int'(bus_b.evt_valid), 0);

        // Backpressure: second press inside lockout is silently ignored
        do_reset();
        bus_a.evt_ready = 1'b0;
        bus_a.pulse_in = 4'b0010; cycle();
        bus_a.pulse_in = 4'b0000; cycle();
        bus_a.pulse_in = 4'b0010; cycle();
        bus_a.pulse_in = 4'b0000; cycle(); cycle();
        chk("bp_valid_held", int'(bus_a.evt_valid), 1);
        chk("bp_id_held",    int'(bus_a.evt_id),    1);
        chk("bp_no_loss",    int'(bus_a.evt_lost),  0);
        bus_a.evt_ready = 1'b1; cycle();
        chk("bp_drained", int'(bus_a.evt_valid), 0);

        // Loss with LOCKOUT=0, sticky flag, set beats clear
        do_reset();
        bus_b.evt_ready = 1'b0;
        bus_b.pulse_in = 4'b0010; cycle();
        bus_b.pulse_in = 4'b0000; cycle();
        bus_b.pulse_in = 4'b0010; cycle();
        cycle();
        chk("loss_set",  int'(bus_b.evt_lost), 1);
        chk("loss_hold_id", int'(bus_b.evt_id), 1);
        bus_b.pulse_in = 4'b0000; cycle(); cycle();
        chk("loss_sticky", int'(bus_b.evt_lost), 1);
        bus_b.pulse_in = 4'b0010; bus_b.clr_lost = 1'b1; cycle();
        chk("loss_set_beats_clr", int'(bus_b.evt_lost), 1);
        bus_b.pulse_in = 4'b0000; cycle();
        chk("loss_cleared", int'(bus_b.evt_lost), 0);
        bus_b.clr_lost = 1'b0; bus_b.evt_ready = 1'b1; cycle();
        chk("no_bubble_valid", int'(bus_b.evt_valid), 1);
        chk("no_bubble_id",    int'(bus_b.evt_id),    1);
        cycle();
        chk("loss_drained", int'(bus_b.evt_valid), 0);

        // Lockout boundary: G+8 ignored, G+9 accepted
        do_reset();
        bus_a.evt_ready = 1'b1;
        bus_a.pulse_in = 4'b0001; cycle();
        bus_a.pulse_in = 4'b0000; cycle();
        chk("lock_grant_id0", int'(bus_a.evt_id), 0);
        for (int k = 0; k < 7; k++) cycle();
        bus_a.pulse_in = 4'b0001; cycle();
        cycle();
        chk("lock_g8_ignored", int'(bus_a.evt_valid), 0);
        bus_a.pulse_in = 4'b0000; cycle();
        chk("lock_g9_valid", int'(bus_a.evt_valid), 1);
        chk("lock_g9_id",    int'(bus_a.evt_id),    0);
        cycle();

        // Asynchronous reset mid-handshake
        do_reset();
        bus_b.evt_ready = 1'b0;
        bus_b.pulse_in = 4'b0010; cycle();
        bus_b.pulse_in = 4'b0000; cycle();
        bus_b.pulse_in = 4'b0101; cycle();
        bus_b.pulse_in = 4'b0001; cycle();
        bus_b.pulse_in = 4'b0000;
        chk("pre_rst_valid", int'(bus_b.evt_valid), 1);
        chk("pre_rst_lost",  int'(bus_b.evt_lost),  1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", int'(bus_b.evt_valid), 0);
        chk("async_rst_id",    int'(bus_b.evt_id),    0);
        chk("async_rst_lost",  int'(bus_b.evt_lost),  0);
        cycle();
        rst = 1'b0;
        bus_b.evt_ready = 1'b1;
        cycle(); cycle(); cycle();
        chk("post_rst_no_event", int'(bus_b.evt_valid), 0);
        bus_b.pulse_in = 4'b0100; cycle();
        bus_b.pulse_in = 4'b0000; cycle();
        chk("post_rst_valid", int'(bus_b.evt_valid), 1);
        chk("post_rst_id",    int'(bus_b.evt_id),    2);
        cycle();
        chk("post_rst_idle",  int'(bus_b.evt_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
